// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the serial register link (transmitter and matching receiver).
// The bit counter width is exposed so both ends size their counters identically.
package piso_serializer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_PARITY = 2'd2;

  // Counter holds "bits still to emit after so", so it must reach WIDTH-1 without wrapping.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle for the serializer: master is the word source, slave is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din, load_valid,
    input  load_ready, so, so_valid, frame_start, busy
  );

  modport slave (
    input  din, load_valid,
    output load_ready, so, so_valid, frame_start, busy
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per frame, one bit per clk, first bit the cycle after accept.
// Optional trailing even-parity bit per frame when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             so_q;
  logic             so_valid_q;
  logic             frame_start_q;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] din_rest;
  logic [WIDTH-1:0] shreg_next;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  // The bit to send next always sits at the outgoing end of shreg; the far end fills with zeros.
  assign first_bit  = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign next_bit   = MSB_FIRST ? shreg[WIDTH-1]   : shreg[0];
  assign din_rest   = MSB_FIRST ? (bus.din << 1)   : (bus.din >> 1);
  assign shreg_next = MSB_FIRST ? (shreg << 1)     : (shreg >> 1);

`ifdef PISO_SERIALIZER_PARITY_EN
  assign bus.load_ready = (state == ST_IDLE) || (state == ST_PARITY);
`else
  assign bus.load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && (cnt == '0));
`endif

  assign accept          = bus.load_valid && bus.load_ready;
  assign bus.so          = so_q;
  assign bus.so_valid    = so_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      cnt           <= '0;
      so_q          <= 1'b0;
      so_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (accept) begin
      // Accept wins from any ready state, which is what lets frames abut with no idle gap.
      state         <= ST_SHIFT;
      shreg         <= din_rest;
      cnt           <= CW'(WIDTH - 1);
      so_q          <= first_bit;
      so_valid_q    <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      frame_start_q <= 1'b0;
      case (state)
        ST_SHIFT: begin
          if (cnt != '0) begin
            shreg <= shreg_next;
            cnt   <= cnt - CW'(1);
            so_q  <= next_bit;
          end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state <= ST_PARITY;
            so_q  <= parity_q;
`else
            state      <= ST_IDLE;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
`endif
          end
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          state      <= ST_IDLE;
          so_q       <= 1'b0;
          so_valid_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.din;
    end
  end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer instances (W4 MSB-first, W4 LSB-first, W1) against a queue-based frame model.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL  = 4 + PAR;
  localparam int FL1 = 1 + PAR;

  typedef struct packed {
    logic b;
    logic fs;
  } ent_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  piso_serializer_if #(.WIDTH(4)) ia ();
  piso_serializer_if #(.WIDTH(4)) ib ();
  piso_serializer_if #(.WIDTH(1)) ic ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ib));
  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed and modelled {so, so_valid, frame_start, load_ready, busy}.
  wire [4:0] obs_a = {ia.so, ia.so_valid, ia.frame_start, ia.load_ready, ia.busy};
  wire [4:0] obs_b = {ib.so, ib.so_valid, ib.frame_start, ib.load_ready, ib.busy};
  wire [4:0] obs_c = {ic.so, ic.so_valid, ic.frame_start, ic.load_ready, ic.busy};
  logic [4:0] mdl_a = 5'b00010;
  logic [4:0] mdl_b = 5'b00010;
  logic [4:0] mdl_c = 5'b00010;

  // A frame is the word's bits in send order, plus an even-parity bit when enabled.
  function automatic int frame(input int w, input bit msb, input logic [3:0] d, output logic [4:0] fb);
    logic p;
    p  = 1'b0;
    fb = '0;
    for (int k = 0; k < w; k++) begin
      fb[k] = msb ? d[w-1-k] : d[k];
      p     = p ^ d[k];
    end
    if (PAR != 0) fb[w] = p;
    return w + PAR;
  endfunction

  // Model: a word is taken only when no frame bits remain queued; one queued bit is shown per clock.
  ent_t qa[$];
  int n_a; logic [4:0] fb_a; ent_t e_a;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete(); mdl_a = 5'b00010;
    end else begin
      if (ia.load_valid && qa.size() == 0) begin
        n_a = frame(4, 1'b1, ia.din, fb_a);
        for (int k = 0; k < n_a; k++) qa.push_back({fb_a[k], 1'(k == 0)});
      end
      if (qa.size() != 0) begin
        e_a = qa.pop_front(); mdl_a = {e_a.b, 1'b1, e_a.fs, 1'(qa.size() == 0), 1'b1};
      end else mdl_a = 5'b00010;
    end
  end

  ent_t qb[$];
  int n_b; logic [4:0] fb_b; ent_t e_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qb.delete(); mdl_b = 5'b00010;
    end else begin
      if (ib.load_valid && qb.size() == 0) begin
        n_b = frame(4, 1'b0, ib.din, fb_b);
        for (int k = 0; k < n_b; k++) qb.push_back({fb_b[k], 1'(k == 0)});
      end
      if (qb.size() != 0) begin
        e_b = qb.pop_front(); mdl_b = {e_b.b, 1'b1, e_b.fs, 1'(qb.size() == 0), 1'b1};
      end else mdl_b = 5'b00010;
    end
  end

  ent_t qc[$];
  int n_c; logic [4:0] fb_c; ent_t e_c;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qc.delete(); mdl_c = 5'b00010;
    end else begin
      if (ic.load_valid && qc.size() == 0) begin
        n_c = frame(1, 1'b1, {3'b000, ic.din}, fb_c);
        for (int k = 0; k < n_c; k++) qc.push_back({fb_c[k], 1'(k == 0)});
      end
      if (qc.size() != 0) begin
        e_c = qc.pop_front(); mdl_c = {e_c.b, 1'b1, e_c.fs, 1'(qc.size() == 0), 1'b1};
      end else mdl_c = 5'b00010;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({obs_a, obs_b, obs_c} !== {3{5'b00010}}) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", {obs_a, obs_b, obs_c}, {3{5'b00010}});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({obs_a, obs_b, obs_c} !== {3{5'b00010}}) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", {obs_a, obs_b, obs_c}, {3{5'b00010}});
    end
  endtask

  task automatic test_single();
    logic [0:5] t1;
    t1 = (PAR != 0) ? 6'b101110 : 6'b101100;
    ia.din = 4'b1011; ia.load_valid = 1'b1;
    @(negedge clk);
    ia.load_valid = 1'b0;
    for (int k = 1; k <= FL + 1; k++) begin
      checks++;
      if ({ia.so, ia.so_valid, ia.frame_start} !== {t1[k-1], 1'(k <= FL), 1'(k == 1)}) begin
        errors++; $display("FAIL single_bits k=%0d got=%b exp=%b", k,
                           {ia.so, ia.so_valid, ia.frame_start}, {t1[k-1], 1'(k <= FL), 1'(k == 1)});
      end
      checks++;
      if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
        errors++; $display("FAIL single_model k=%0d got=%b exp=%b", k, {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:10] t2;
    t2 = (PAR != 0) ? 11'b10111011000 : 11'b10110110000;
    ia.din = 4'b1011; ia.load_valid = 1'b1;
    @(negedge clk);
    ia.din = 4'b0110;
    for (int k = 1; k <= 2 * FL + 1; k++) begin
      checks++;
      if ({ia.so, ia.so_valid, ia.frame_start} !== {t2[k-1], 1'(k <= 2 * FL), 1'(k == 1 || k == FL + 1)}) begin
        errors++; $display("FAIL b2b_bits k=%0d got=%b exp=%b", k, {ia.so, ia.so_valid, ia.frame_start},
                           {t2[k-1], 1'(k <= 2 * FL), 1'(k == 1 || k == FL + 1)});
      end
      checks++;
      if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
        errors++; $display("FAIL b2b_model k=%0d got=%b exp=%b", k, {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
      end
      if (k == FL + 1) ia.load_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_lsb_hold();
    logic [0:3] t3;
    t3 = 4'b1000;
    ib.din = 4'b0001; ib.load_valid = 1'b1;
    @(negedge clk);
    ib.load_valid = 1'b0;
    for (int k = 1; k <= 2 * FL + 1; k++) begin
      if (k <= 4) begin
        checks++;
        if (ib.so !== t3[k-1]) begin
          errors++; $display("FAIL lsb_bit k=%0d got=%b exp=%b", k, ib.so, t3[k-1]);
        end
      end
      if (k == 3) begin
        checks++;
        if (ib.load_ready !== 1'b0) begin
          errors++; $display("FAIL lsb_ready_midframe got=%b exp=0", ib.load_ready);
        end
      end
      if (k == FL + 1) begin
        checks++;
        if ({ib.so, ib.so_valid, ib.frame_start} !== 3'b111) begin
          errors++; $display("FAIL lsb_second_start got=%b exp=111", {ib.so, ib.so_valid, ib.frame_start});
        end
        ib.load_valid = 1'b0;
      end
      checks++;
      if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
        errors++; $display("FAIL lsb_model k=%0d got=%b exp=%b", k, {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
      end
      if (k == 2) begin
        ib.din = 4'b1111; ib.load_valid = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [0:3] t4;
    t4 = 4'b1100;
    ia.din = 4'b1100; ia.load_valid = 1'b1;
    @(negedge clk);
    ia.load_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ia.so, ia.so_valid, ia.busy} !== 3'b011) begin
      errors++; $display("FAIL rstmid_third_bit got=%b exp=011", {ia.so, ia.so_valid, ia.busy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ia.so, ia.so_valid, ia.frame_start, ia.busy} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async got=%b exp=0000", {ia.so, ia.so_valid, ia.frame_start, ia.busy});
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
      errors++; $display("FAIL rstmid_idle got=%b exp=%b", {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
    end
    ia.load_valid = 1'b1;
    @(negedge clk);
    ia.load_valid = 1'b0;
    for (int k = 1; k <= FL + 1; k++) begin
      if (k <= 4) begin
        checks++;
        if ({ia.so, ia.frame_start} !== {t4[k-1], 1'(k == 1)}) begin
          errors++; $display("FAIL rstmid_refrm k=%0d got=%b exp=%b", k, {ia.so, ia.frame_start}, {t4[k-1], 1'(k == 1)});
        end
      end
      checks++;
      if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
        errors++; $display("FAIL rstmid_model k=%0d got=%b exp=%b", k, {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
      end
      @(negedge clk);
    end
  endtask

`ifdef PISO_SERIALIZER_PARITY_EN
  task automatic test_parity();
    ia.din = 4'b1001; ia.load_valid = 1'b1;
    @(negedge clk);
    ia.load_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) begin
        checks++;
        if (ia.load_ready !== 1'b0) begin
          errors++; $display("FAIL parity_ready_last_data got=%b exp=0", ia.load_ready);
        end
      end
      if (k == 5) begin
        checks++;
        if ({ia.so, ia.so_valid, ia.frame_start, ia.load_ready} !== 4'b0101) begin
          errors++; $display("FAIL parity_bit got=%b exp=0101", {ia.so, ia.so_valid, ia.frame_start, ia.load_ready});
        end
      end
      checks++;
      if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
        errors++; $display("FAIL parity_model k=%0d got=%b exp=%b", k, {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_width1();
    logic [0:2] s;
    s = 3'b101;
    for (int i = 0; i < 3; i++) begin
      ic.din = s[i]; ic.load_valid = 1'b1;
      for (int j = 0; j < FL1; j++) begin
        @(negedge clk);
        if (j == 0) begin
          checks++;
          if ({ic.so, ic.so_valid, ic.frame_start} !== {s[i], 2'b11}) begin
            errors++; $display("FAIL w1_bit i=%0d got=%b exp=%b", i, {ic.so, ic.so_valid, ic.frame_start}, {s[i], 2'b11});
          end
        end
        checks++;
        if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
          errors++; $display("FAIL w1_model i=%0d got=%b exp=%b", i, {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
        end
      end
    end
    ic.load_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ic.so_valid, ic.busy} !== 2'b00) begin
      errors++; $display("FAIL w1_idle got=%b exp=00", {ic.so_valid, ic.busy});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ia.load_valid = ($urandom_range(0, 9) < 7); ia.din = 4'($urandom);
      ib.load_valid = ($urandom_range(0, 9) < 7); ib.din = 4'($urandom);
      ic.load_valid = ($urandom_range(0, 9) < 7); ic.din = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b, obs_c} !== {mdl_a, mdl_b, mdl_c}) begin
        errors++; $display("FAIL random_model n=%0d got=%b exp=%b", n, {obs_a, obs_b, obs_c}, {mdl_a, mdl_b, mdl_c});
      end
    end
    ia.load_valid = 1'b0; ib.load_valid = 1'b0; ic.load_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({obs_a, obs_b, obs_c} !== {3{5'b00010}}) begin
      errors++; $display("FAIL random_drain got=%b exp=%b", {obs_a, obs_b, obs_c}, {3{5'b00010}});
    end
  endtask

  initial begin
    rst = 1'b1;
    ia.din = '0; ia.load_valid = 1'b0;
    ib.din = '0; ib.load_valid = 1'b0;
    ic.din = '0; ic.load_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_hold();
    test_reset_mid();
`ifdef PISO_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_width1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
